// File: rtl/as_memaccess.sv
// RV64I memory-access stage: data-memory handshake, load alignment/extension and MEM/WB register.
// Optional MISALIGN_TRAP_EN: misaligned accesses retire without a request and flag wb_misalign_o.
module as_memaccess #(
  parameter int XLEN    = 64,
  parameter int DADDR_W = 32,
  parameter int IADDR_W = 32
) (
  input  logic               clk_i,
  input  logic               rstn_i,
  input  logic               valid_i,
  input  logic [XLEN-1:0]    alu_result_i,
  input  logic [XLEN-1:0]    store_data_i,
  input  logic [2:0]         funct3_i,
  input  logic               mem_read_i,
  input  logic               mem_write_i,
  input  logic [1:0]         mux_result_src_i,
  input  logic [IADDR_W-1:0] return_address_i,
  input  logic [4:0]         rd_i,
  input  logic               reg_write_i,
  output logic               stall_o,
  output logic               dmem_req_o,
  output logic               dmem_we_o,
  output logic [DADDR_W-1:0] dmem_addr_o,
  output logic [7:0]         dmem_be_o,
  output logic [XLEN-1:0]    dmem_wdata_o,
  input  logic               dmem_gnt_i,
  input  logic               dmem_rvalid_i,
  input  logic [XLEN-1:0]    dmem_rdata_i,
  output logic               wb_valid_o,
  output logic [XLEN-1:0]    wb_alu_result_o,
  output logic [XLEN-1:0]    wb_data_mem_o,
  output logic [IADDR_W-1:0] wb_return_address_o,
  output logic [1:0]         wb_mux_result_src_o,
  output logic [4:0]         wb_rd_o,
  output logic               wb_reg_write_o
`ifdef MISALIGN_TRAP_EN
  ,
  output logic               wb_misalign_o
`endif
);

  typedef enum logic [1:0] {IDLE, WAIT_GNT, WAIT_RVALID} state_t;

  state_t            state;
  logic [2:0]        a_raw, a_al, cap_a, cap_f3;
  logic              misalign, mem_op;
  logic [7:0]        be_raw;
  logic [XLEN-1:0]   wdata_raw, shifted, load_data;

  assign a_raw = alu_result_i[2:0];

  // Byte offset rounded down to the natural alignment of the access size.
  always_comb begin
    case (funct3_i[1:0])
      2'b00:   a_al = a_raw;
      2'b01:   a_al = {a_raw[2:1], 1'b0};
      2'b10:   a_al = {a_raw[2], 2'b00};
      default: a_al = 3'b000;
    endcase
  end

`ifdef MISALIGN_TRAP_EN
  assign misalign = valid_i & (mem_read_i | mem_write_i) & (a_al != a_raw);
`else
  assign misalign = 1'b0;
`endif

  assign mem_op     = valid_i & (mem_read_i | mem_write_i) & ~misalign;
  assign dmem_req_o = mem_op & (state != WAIT_RVALID);
  assign dmem_we_o  = dmem_req_o & mem_write_i;
  assign dmem_addr_o = dmem_req_o ? {alu_result_i[DADDR_W-1:3], 3'b000} : '0;

  always_comb begin
    be_raw = 8'h00;
    case (funct3_i[1:0])
      2'b00:   be_raw = 8'h01 << a_al;
      2'b01:   be_raw = 8'h03 << a_al;
      2'b10:   be_raw = 8'h0F << a_al;
      default: be_raw = 8'hFF;
    endcase
  end

  assign dmem_be_o = dmem_req_o ? be_raw : 8'h00;

  // Each lane picks the store-data byte that repeats into it for the access size.
  for (genvar gi = 0; gi < 8; gi++) begin : g_lane
    localparam logic [2:0] LANE = 3'(gi);
    logic [2:0] src;
    always_comb begin
      case (funct3_i[1:0])
        2'b00:   src = 3'd0;
        2'b01:   src = {2'b00, LANE[0]};
        2'b10:   src = {1'b0, LANE[1:0]};
        default: src = LANE;
      endcase
    end
    assign wdata_raw[gi*8 +: 8] = store_data_i[{src, 3'b000} +: 8];
  end

  assign dmem_wdata_o = dmem_we_o ? wdata_raw : '0;

  always_comb begin
    stall_o = 1'b0;
    if (state == WAIT_RVALID)
      stall_o = ~dmem_rvalid_i;
    else if (mem_op)
      stall_o = ~(dmem_gnt_i & mem_write_i);
  end

  assign shifted = dmem_rdata_i >> {cap_a, 3'b000};

  always_comb begin
    case (cap_f3)
      3'b000:  load_data = {{(XLEN-8){shifted[7]}},   shifted[7:0]};
      3'b001:  load_data = {{(XLEN-16){shifted[15]}}, shifted[15:0]};
      3'b010:  load_data = {{(XLEN-32){shifted[31]}}, shifted[31:0]};
      3'b100:  load_data = {{(XLEN-8){1'b0}},         shifted[7:0]};
      3'b101:  load_data = {{(XLEN-16){1'b0}},        shifted[15:0]};
      3'b110:  load_data = {{(XLEN-32){1'b0}},        shifted[31:0]};
      default: load_data = shifted;
    endcase
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state               <= IDLE;
      cap_a               <= 3'b000;
      cap_f3              <= 3'b000;
      wb_valid_o          <= 1'b0;
      wb_alu_result_o     <= '0;
      wb_data_mem_o       <= '0;
      wb_return_address_o <= '0;
      wb_mux_result_src_o <= 2'b00;
      wb_rd_o             <= 5'd0;
      wb_reg_write_o      <= 1'b0;
`ifdef MISALIGN_TRAP_EN
      wb_misalign_o       <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE, WAIT_GNT: begin
          if (!mem_op)
            state <= IDLE;
          else if (!dmem_gnt_i)
            state <= WAIT_GNT;
          else if (mem_read_i) begin
            state  <= WAIT_RVALID;
            cap_a  <= a_al;
            cap_f3 <= funct3_i;
          end else
            state <= IDLE;
        end
        WAIT_RVALID: if (dmem_rvalid_i) state <= IDLE;
        default:     state <= IDLE;
      endcase

      // Stalled cycles hand writeback a bubble; the payload fields keep their last value.
      if (stall_o) begin
        wb_valid_o     <= 1'b0;
        wb_reg_write_o <= 1'b0;
`ifdef MISALIGN_TRAP_EN
        wb_misalign_o  <= 1'b0;
`endif
      end else begin
        wb_valid_o          <= valid_i;
        wb_reg_write_o      <= valid_i & reg_write_i & ~misalign;
        wb_alu_result_o     <= alu_result_i;
        wb_return_address_o <= return_address_i;
        wb_mux_result_src_o <= mux_result_src_i;
        wb_rd_o             <= rd_i;
        if (state == WAIT_RVALID)
          wb_data_mem_o <= load_data;
`ifdef MISALIGN_TRAP_EN
        wb_misalign_o       <= misalign;
`endif
      end
    end
  end

endmodule

// File: tb/tb_as_memaccess.sv
// Scoreboard bench for as_memaccess: expected retirements are queued at issue and matched by a monitor.
module tb_as_memaccess;

  logic        clk = 1'b0;
  logic        rstn;
  logic        valid, mem_read, mem_write, reg_write, gnt, rvalid;
  logic [63:0] alu_result, store_data, rdata;
  logic [2:0]  funct3;
  logic [1:0]  mux_result_src;
  logic [31:0] return_address;
  logic [4:0]  rd;
  logic        stall, dmem_req, dmem_we, wb_valid, wb_reg_write;
  logic [31:0] dmem_addr, wb_return_address;
  logic [7:0]  dmem_be;
  logic [63:0] dmem_wdata, wb_alu_result, wb_data_mem;
  logic [1:0]  wb_mux_result_src;
  logic [4:0]  wb_rd;
  logic        wb_misalign;

  int tests = 0;
  int fails = 0;

  typedef struct {
    string       name;
    logic [63:0] alu;
    logic [63:0] dm;
    logic        chk_dm;
    logic [31:0] ra;
    logic [1:0]  src;
    logic [4:0]  rd;
    logic        rw;
    logic        mis;
  } exp_t;

  exp_t sb[$];

  always #5 clk = ~clk;

  as_memaccess dut (
    .clk_i(clk), .rstn_i(rstn), .valid_i(valid), .alu_result_i(alu_result),
    .store_data_i(store_data), .funct3_i(funct3), .mem_read_i(mem_read),
    .mem_write_i(mem_write), .mux_result_src_i(mux_result_src),
    .return_address_i(return_address), .rd_i(rd), .reg_write_i(reg_write),
    .stall_o(stall), .dmem_req_o(dmem_req), .dmem_we_o(dmem_we),
    .dmem_addr_o(dmem_addr), .dmem_be_o(dmem_be), .dmem_wdata_o(dmem_wdata),
    .dmem_gnt_i(gnt), .dmem_rvalid_i(rvalid), .dmem_rdata_i(rdata),
    .wb_valid_o(wb_valid), .wb_alu_result_o(wb_alu_result), .wb_data_mem_o(wb_data_mem),
    .wb_return_address_o(wb_return_address), .wb_mux_result_src_o(wb_mux_result_src),
    .wb_rd_o(wb_rd), .wb_reg_write_o(wb_reg_write)
`ifdef MISALIGN_TRAP_EN
    , .wb_misalign_o(wb_misalign)
`endif
  );

`ifndef MISALIGN_TRAP_EN
  assign wb_misalign = 1'b0;
`endif

  // Monitor: every retirement must match the oldest queued expectation.
  always @(negedge clk) begin
    if (rstn && wb_valid) begin
      tests++;
      if (sb.size() == 0) begin
        fails++;
        $display("[TB] FAIL unexpected_wb got alu=%h rd=%0d, required no retirement", wb_alu_result, wb_rd);
      end else begin
        exp_t e;
        e = sb.pop_front();
        if (wb_alu_result !== e.alu || wb_rd !== e.rd || wb_reg_write !== e.rw ||
            wb_return_address !== e.ra || wb_mux_result_src !== e.src ||
            wb_misalign !== e.mis || (e.chk_dm && wb_data_mem !== e.dm)) begin
          fails++;
          $display("[TB] FAIL wb_%0s got alu=%h dm=%h rd=%0d rw=%b ra=%h src=%0d mis=%b, required alu=%h dm=%h rd=%0d rw=%b ra=%h src=%0d mis=%b",
                   e.name, wb_alu_result, wb_data_mem, wb_rd, wb_reg_write, wb_return_address,
                   wb_mux_result_src, wb_misalign, e.alu, e.dm, e.rd, e.rw, e.ra, e.src, e.mis);
        end else
          $display("[TB] retire %0s alu=%h dm=%h rd=%0d rw=%b", e.name, wb_alu_result, wb_data_mem, wb_rd, wb_reg_write);
      end
    end
  end

  task automatic set_op(input logic v, input logic rd_op, input logic wr_op, input logic [2:0] f3,
                        input logic [63:0] alu, input logic [63:0] sd, input logic [4:0] rdn,
                        input logic rw);
    valid = v; mem_read = rd_op; mem_write = wr_op; funct3 = f3;
    alu_result = alu; store_data = sd; rd = rdn; reg_write = rw;
    return_address = 32'h0000_1000 | {27'd0, rdn};
    mux_result_src = rdn[1:0];
  endtask

  task automatic push(input string nm, input logic [63:0] alu, input logic [63:0] dm,
                      input logic chk, input logic [4:0] rdn, input logic rw, input logic mis);
    exp_t e;
    e.name = nm; e.alu = alu; e.dm = dm; e.chk_dm = chk; e.rd = rdn; e.rw = rw; e.mis = mis;
    e.ra = 32'h0000_1000 | {27'd0, rdn};
    e.src = rdn[1:0];
    sb.push_back(e);
  endtask

  task automatic test_reset;
    rstn = 1'b0; gnt = 1'b0; rvalid = 1'b0; rdata = '0;
    set_op(1'b0, 1'b0, 1'b0, 3'd0, 64'd0, 64'd0, 5'd0, 1'b0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    tests++;
    if ({stall, dmem_req, dmem_we, dmem_be, dmem_addr, dmem_wdata, wb_valid, wb_reg_write,
         wb_alu_result, wb_data_mem, wb_return_address, wb_mux_result_src, wb_rd, wb_misalign} !== '0) begin
      fails++;
      $display("[TB] FAIL reset_state got stall=%b req=%b wb_valid=%b wb_alu=%h, required all zero",
               stall, dmem_req, wb_valid, wb_alu_result);
    end
    @(posedge clk); #1 rstn = 1'b1;
  endtask

  task automatic test_alu;
    @(posedge clk); #1;
    set_op(1'b1, 1'b0, 1'b0, 3'd0, 64'h1234, 64'd0, 5'd3, 1'b1);
    push("alu", 64'h1234, 64'd0, 1'b0, 5'd3, 1'b1, 1'b0);
    @(negedge clk);
    tests++;
    if (stall !== 1'b0 || dmem_req !== 1'b0) begin
      fails++; $display("[TB] FAIL alu_stall got stall=%b req=%b, required 0 0", stall, dmem_req);
    end
    @(posedge clk); #1 set_op(1'b0, 1'b0, 1'b0, 3'd0, 64'd0, 64'd0, 5'd0, 1'b0);
    @(negedge clk);
    tests++;
    if (stall !== 1'b0) begin
      fails++; $display("[TB] FAIL alu_stall2 got %b, required 0", stall);
    end
  endtask

  task automatic test_back_to_back;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      set_op(1'b1, 1'b0, 1'b0, 3'd0, 64'hA000 + 64'(i), 64'd0, 5'(10 + i), i[0]);
      push($sformatf("b2b%0d", i), 64'hA000 + 64'(i), 64'd0, 1'b0, 5'(10 + i), i[0], 1'b0);
      @(negedge clk);
      tests++;
      if (stall !== 1'b0) begin
        fails++; $display("[TB] FAIL b2b_stall%0d got %b, required 0", i, stall);
      end
    end
    @(posedge clk); #1 set_op(1'b0, 1'b0, 1'b0, 3'd0, 64'hBAD, 64'd0, 5'd9, 1'b1);
    @(posedge clk); #1;
    @(negedge clk);
    tests++;
    if (wb_valid !== 1'b0 || wb_reg_write !== 1'b0) begin
      fails++; $display("[TB] FAIL b2b_bubble got valid=%b rw=%b, required 0 0", wb_valid, wb_reg_write);
    end
    tests++;
    if (sb.size() != 0) begin
      fails++; $display("[TB] FAIL b2b_drain got %0d pending, required 0", sb.size());
    end
  endtask

  typedef struct {
    string nm; logic [2:0] f3; logic [63:0] addr; logic [63:0] rd; int dly; logic [63:0] exp;
  } ld_t;

  task automatic test_loads;
    ld_t t[7];
    t[0] = '{"lb",  3'b000, 64'h13, 64'h0102_0304_8055_6677, 0, 64'hFFFF_FFFF_FFFF_FF80};
    t[1] = '{"lbu", 3'b100, 64'h13, 64'h0102_0304_8055_6677, 0, 64'h0000_0000_0000_0080};
    t[2] = '{"lh",  3'b001, 64'h06, 64'h8123_4567_89AB_CDEF, 0, 64'hFFFF_FFFF_FFFF_8123};
    t[3] = '{"lhu", 3'b101, 64'h06, 64'h8123_4567_89AB_CDEF, 1, 64'h0000_0000_0000_8123};
    t[4] = '{"lw",  3'b010, 64'h44, 64'h8000_0001_1234_5678, 0, 64'hFFFF_FFFF_8000_0001};
    t[5] = '{"lwu", 3'b110, 64'h44, 64'h8000_0001_1234_5678, 0, 64'h0000_0000_8000_0001};
    t[6] = '{"ld",  3'b011, 64'h20, 64'hDEAD_BEEF_CAFE_F00D, 4, 64'hDEAD_BEEF_CAFE_F00D};
    for (int i = 0; i < 7; i++) begin
      @(posedge clk); #1;
      set_op(1'b1, 1'b1, 1'b0, t[i].f3, t[i].addr, 64'd0, 5'(20 + i), 1'b1);
      gnt = 1'b1;
      push(t[i].nm, t[i].addr, t[i].exp, 1'b1, 5'(20 + i), 1'b1, 1'b0);
      @(negedge clk);
      tests++;
      if ({dmem_req, dmem_we, stall, dmem_addr} !== {3'b101, t[i].addr[31:3], 3'b000}) begin
        fails++;
        $display("[TB] FAIL %0s_issue got req=%b we=%b stall=%b addr=%h, required 1 0 1 %h",
                 t[i].nm, dmem_req, dmem_we, stall, dmem_addr, {t[i].addr[31:3], 3'b000});
      end
      @(posedge clk); #1 gnt = (t[i].dly > 0); rdata = ~t[i].rd;
      for (int d = 0; d < t[i].dly; d++) begin
        @(negedge clk);
        tests++;
        if (stall !== 1'b1 || wb_valid !== 1'b0 || dmem_req !== 1'b0) begin
          fails++;
          $display("[TB] FAIL %0s_wait%0d got stall=%b wb_valid=%b req=%b, required 1 0 0",
                   t[i].nm, d, stall, wb_valid, dmem_req);
        end
        @(posedge clk); #1;
      end
      gnt = 1'b0; rvalid = 1'b1; rdata = t[i].rd;
      @(negedge clk);
      tests++;
      if (stall !== 1'b0) begin
        fails++; $display("[TB] FAIL %0s_release got stall=%b, required 0", t[i].nm, stall);
      end
      @(posedge clk); #1;
      rvalid = 1'b0; rdata = '0;
      set_op(1'b0, 1'b0, 1'b0, 3'd0, 64'd0, 64'd0, 5'd0, 1'b0);
      @(posedge clk); #1;
      tests++;
      if (sb.size() != 0) begin
        fails++; $display("[TB] FAIL %0s_drain got %0d pending, required 0", t[i].nm, sb.size());
      end
    end
  endtask

  typedef struct {
    string nm; logic [2:0] f3; logic [63:0] addr; logic [63:0] sd; int gdly; logic [7:0] be; logic [63:0] wd;
  } st_t;

  task automatic test_stores;
    st_t t[4];
    t[0] = '{"sb", 3'b000, 64'h05, 64'h1122_3344_5566_7788, 0, 8'h20, {8{8'h88}}};
    t[1] = '{"sh", 3'b001, 64'h06, 64'h5555_0000_1234_BEEF, 3, 8'hC0, {4{16'hBEEF}}};
    t[2] = '{"sw", 3'b010, 64'h0C, 64'hAAAA_BBBB_CAFE_1234, 0, 8'hF0, {2{32'hCAFE_1234}}};
    t[3] = '{"sd", 3'b011, 64'h18, 64'h0123_4567_89AB_CDEF, 1, 8'hFF, 64'h0123_4567_89AB_CDEF};
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      set_op(1'b1, 1'b0, 1'b1, t[i].f3, t[i].addr, t[i].sd, 5'(i), 1'b0);
      gnt = (t[i].gdly == 0);
      push(t[i].nm, t[i].addr, 64'd0, 1'b0, 5'(i), 1'b0, 1'b0);
      for (int c = 0; c <= t[i].gdly; c++) begin
        if (c == t[i].gdly) gnt = 1'b1;
        @(negedge clk);
        tests++;
        if ({dmem_req, dmem_we, dmem_be, dmem_addr, dmem_wdata, stall} !==
            {2'b11, t[i].be, t[i].addr[31:3], 3'b000, t[i].wd, (c != t[i].gdly)}) begin
          fails++;
          $display("[TB] FAIL %0s_cyc%0d got req=%b we=%b be=%h addr=%h wdata=%h stall=%b, required 1 1 %h %h %h %b",
                   t[i].nm, c, dmem_req, dmem_we, dmem_be, dmem_addr, dmem_wdata, stall,
                   t[i].be, {t[i].addr[31:3], 3'b000}, t[i].wd, (c != t[i].gdly));
        end
        @(posedge clk); #1;
      end
      gnt = 1'b0;
      set_op(1'b0, 1'b0, 1'b0, 3'd0, 64'd0, 64'd0, 5'd0, 1'b0);
      @(posedge clk); #1;
      tests++;
      if (sb.size() != 0) begin
        fails++; $display("[TB] FAIL %0s_drain got %0d pending, required 0", t[i].nm, sb.size());
      end
    end
  endtask

  task automatic test_misalign;
    @(posedge clk); #1;
    set_op(1'b1, 1'b1, 1'b0, 3'b010, 64'h2, 64'd0, 5'd17, 1'b1);
`ifdef MISALIGN_TRAP_EN
    push("lw_mis", 64'h2, 64'd0, 1'b0, 5'd17, 1'b0, 1'b1);
    @(negedge clk);
    tests++;
    if (dmem_req !== 1'b0 || stall !== 1'b0) begin
      fails++; $display("[TB] FAIL mis_noreq got req=%b stall=%b, required 0 0", dmem_req, stall);
    end
    @(posedge clk); #1;
`else
    gnt = 1'b1;
    push("lw_align", 64'h2, 64'hFFFF_FFFF_9555_6666, 1'b1, 5'd17, 1'b1, 1'b0);
    @(negedge clk);
    tests++;
    if (dmem_req !== 1'b1 || dmem_addr !== 32'h0) begin
      fails++; $display("[TB] FAIL align_req got req=%b addr=%h, required 1 0", dmem_req, dmem_addr);
    end
    @(posedge clk); #1 gnt = 1'b0; rvalid = 1'b1; rdata = 64'h3333_4444_9555_6666;
    @(posedge clk); #1 rvalid = 1'b0;
`endif
    set_op(1'b0, 1'b0, 1'b0, 3'd0, 64'd0, 64'd0, 5'd0, 1'b0);
    @(posedge clk); #1;
    tests++;
    if (sb.size() != 0) begin
      fails++; $display("[TB] FAIL mis_drain got %0d pending, required 0", sb.size());
    end
  endtask

  task automatic test_reset_mid;
    @(posedge clk); #1;
    set_op(1'b1, 1'b1, 1'b0, 3'b011, 64'h8, 64'd0, 5'd30, 1'b1);
    gnt = 1'b1;
    @(posedge clk); #1 gnt = 1'b0;
    @(negedge clk);
    tests++;
    if (stall !== 1'b1) begin
      fails++; $display("[TB] FAIL rst_mid_wait got stall=%b, required 1", stall);
    end
    #2 rstn = 1'b0;
    set_op(1'b0, 1'b0, 1'b0, 3'd0, 64'd0, 64'd0, 5'd0, 1'b0);
    #1;
    tests++;
    if ({stall, dmem_req, wb_valid, wb_reg_write, wb_alu_result, wb_rd} !== '0) begin
      fails++; $display("[TB] FAIL rst_mid_async got stall=%b req=%b wb_valid=%b, required 0", stall, dmem_req, wb_valid);
    end
    @(posedge clk); #1 rstn = 1'b1;
    @(posedge clk); #1 rvalid = 1'b1; rdata = 64'hFFFF_0000_FFFF_0000;
    @(negedge clk);
    tests++;
    if (stall !== 1'b0 || dmem_req !== 1'b0) begin
      fails++; $display("[TB] FAIL rst_stray got stall=%b req=%b, required 0 0", stall, dmem_req);
    end
    @(posedge clk); #1 rvalid = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      tests++;
      if (wb_valid !== 1'b0 || stall !== 1'b0) begin
        fails++; $display("[TB] FAIL rst_idle%0d got wb_valid=%b stall=%b, required 0 0", c, wb_valid, stall);
      end
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset;
    test_alu;
    test_back_to_back;
    test_loads;
    test_stores;
    test_misalign;
    test_reset_mid;
    repeat (2) @(posedge clk);
    tests++;
    if (sb.size() != 0) begin
      fails++; $display("[TB] FAIL final_drain got %0d pending, required 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
